// File: rtl/jpeg_rle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_rle_pkg
// Description : Shared types and constants for the zig-zag / run-length
//               stage: symbol encoding, scanner states, block geometry and
//               the JPEG zig-zag scan table.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_rle_pkg;

    localparam int DEF_COEF_W = 8;
    localparam int DEF_RUN_W  = 4;
    localparam int BLOCK_SIZE = 64;

    // Symbol codes as seen by the Huffman coder
    typedef enum logic [1:0] {
        SYM_DC  = 2'd0,
        SYM_AC  = 2'd1,
        SYM_ZRL = 2'd2,
        SYM_EOB = 2'd3
    } sym_type_t;

    // Block is either being filled from the quantizer or being scanned out
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_SCAN = 1'b1
    } rle_state_t;

    // Zig-zag position -> raster address (row*8+col)
    localparam logic [5:0] ZIGZAG_TABLE [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage
`default_nettype wire

// File: rtl/jpeg_zigzag_rom.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_zigzag_rom
// Description : Combinational lookup from zig-zag scan index to raster
//               address within an 8x8 block.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_zigzag_rom
    import jpeg_rle_pkg::*;
(
    input  logic [5:0] zz_idx,
    output logic [5:0] raster_addr
);

    assign raster_addr = ZIGZAG_TABLE[zz_idx];

endmodule
`default_nettype wire

// File: rtl/jpeg_zigzag_rle.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_zigzag_rle
// Description : Buffers one 8x8 block of quantized coefficients in raster
//               order, rescans it in zig-zag order and emits DC / AC / ZRL /
//               EOB run-length symbols on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_zigzag_rle
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_type,
    output logic [RUN_W-1:0]         out_run,
    output logic signed [COEF_W-1:0] out_value,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [5:0] LAST_ADDR = 6'(BLOCK_SIZE - 1);

    rle_state_t               r_state,       w_state_nxt;
    logic [5:0]               r_wr_cnt,      w_wr_cnt_nxt;
    logic [5:0]               r_zz_idx,      w_zz_idx_nxt;
    logic [5:0]               r_run,         w_run_nxt;
    logic                     r_out_valid,   w_out_valid_nxt;
    sym_type_t                r_out_type,    w_out_type_nxt;
    logic [RUN_W-1:0]         r_out_run,     w_out_run_nxt;
    logic signed [COEF_W-1:0] r_out_value,   w_out_value_nxt;
    logic                     r_out_last,    w_out_last_nxt;

    logic signed [COEF_W-1:0] r_buf [0:BLOCK_SIZE-1];

    logic [5:0]               w_raster_addr;
    logic signed [COEF_W-1:0] w_coef;
    logic                     w_wr_en;
    logic                     w_slot_free;

    jpeg_zigzag_rom u_rom (
        .zz_idx      (r_zz_idx),
        .raster_addr (w_raster_addr)
    );

    assign w_coef      = r_buf[w_raster_addr];
    assign w_wr_en     = (r_state == ST_FILL) && in_valid && !RST_I;
    assign w_slot_free = !r_out_valid || out_ready;

    assign in_ready  = (r_state == ST_FILL) && !RST_I;
    assign busy      = (r_state == ST_SCAN);
    assign out_valid = r_out_valid;
    assign out_type  = r_out_type;
    assign out_run   = r_out_run;
    assign out_value = r_out_value;
    assign out_last  = r_out_last;

    // Coefficient storage; contents are fully rewritten before every scan
    always_ff @(posedge CLK_I) begin
        if (w_wr_en) begin
            r_buf[r_wr_cnt] <= in_data;
        end
    end

    // State, counters and the registered output slot
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= ST_FILL;
            r_wr_cnt    <= 6'd0;
            r_zz_idx    <= 6'd0;
            r_run       <= 6'd0;
            r_out_valid <= 1'b0;
            r_out_type  <= SYM_DC;
            r_out_run   <= '0;
            r_out_value <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_zz_idx    <= w_zz_idx_nxt;
            r_run       <= w_run_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_type  <= w_out_type_nxt;
            r_out_run   <= w_out_run_nxt;
            r_out_value <= w_out_value_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    // Fill counting, zig-zag scan and symbol generation
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_zz_idx_nxt    = r_zz_idx;
        w_run_nxt       = r_run;
        w_out_valid_nxt = r_out_valid;
        w_out_type_nxt  = r_out_type;
        w_out_run_nxt   = r_out_run;
        w_out_value_nxt = r_out_value;
        w_out_last_nxt  = r_out_last;

        if (r_state == ST_FILL) begin
            if (in_valid) begin
                w_wr_cnt_nxt = r_wr_cnt + 6'd1;
                if (r_wr_cnt == LAST_ADDR) begin
                    w_state_nxt  = ST_SCAN;
                    w_zz_idx_nxt = 6'd0;
                    w_run_nxt    = 6'd0;
                end
            end
        end else begin
            if (r_out_valid && r_out_last) begin
                // Final symbol pending: nothing more to scan, wait for its handshake
                if (out_ready) begin
                    w_state_nxt     = ST_FILL;
                    w_out_valid_nxt = 1'b0;
                    w_out_type_nxt  = SYM_DC;
                    w_out_run_nxt   = '0;
                    w_out_value_nxt = '0;
                    w_out_last_nxt  = 1'b0;
                end
            end else if (w_slot_free) begin
                w_out_valid_nxt = 1'b0;
                if (r_zz_idx == 6'd0) begin
                    // DC is always emitted, even when zero
                    w_out_valid_nxt = 1'b1;
                    w_out_type_nxt  = SYM_DC;
                    w_out_run_nxt   = '0;
                    w_out_value_nxt = w_coef;
                    w_out_last_nxt  = 1'b0;
                    w_zz_idx_nxt    = r_zz_idx + 6'd1;
                end else if (w_coef == '0) begin
                    if (r_zz_idx == LAST_ADDR) begin
                        // Trailing zeros collapse into EOB; pending run is dropped
                        w_out_valid_nxt = 1'b1;
                        w_out_type_nxt  = SYM_EOB;
                        w_out_run_nxt   = '0;
                        w_out_value_nxt = '0;
                        w_out_last_nxt  = 1'b1;
                    end else begin
                        w_run_nxt    = r_run + 6'd1;
                        w_zz_idx_nxt = r_zz_idx + 6'd1;
                    end
                end else if (r_run[5:4] != 2'b00) begin
                    // Run too long for one AC symbol: spend 16 zeros on a ZRL
                    w_out_valid_nxt = 1'b1;
                    w_out_type_nxt  = SYM_ZRL;
                    w_out_run_nxt   = '0;
                    w_out_value_nxt = '0;
                    w_out_last_nxt  = 1'b0;
                    w_run_nxt       = r_run - 6'd16;
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_out_type_nxt  = SYM_AC;
                    w_out_run_nxt   = RUN_W'(r_run[3:0]);
                    w_out_value_nxt = w_coef;
                    w_out_last_nxt  = (r_zz_idx == LAST_ADDR);
                    w_run_nxt       = 6'd0;
                    w_zz_idx_nxt    = r_zz_idx + 6'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/jpeg_zigzag_rle.md
Name: jpeg_zigzag_rle

Overview:
Downstream neighbour of the quantizer stage. Buffers one 8x8 block of signed quantized coefficients that arrive in raster order. It then rescans the block in JPEG zig-zag order and emits run-length symbols: DC, AC(run,value), ZRL and EOB. Its output feeds the Huffman entropy coder through a valid/ready stream.

Parameters:
COEF_W, 8, width of signed quantized coefficient (matches quantizer q_out)
RUN_W, 4, width of zero-run field (max run 15 per JPEG)

Ports:
CLK_I  in  1  clock; all logic on rising edge
RST_I  in  1  reset, synchronous, active-high
in_valid  in  1  input coefficient valid
in_ready  out  1  block accepts coefficient
in_data  in  COEF_W  signed quantized coefficient, raster order (row*8+col)
out_valid  out  1  symbol valid
out_ready  in  1  downstream accepts symbol
out_type  out  2  0=DC, 1=AC, 2=ZRL, 3=EOB
out_run  out  RUN_W  zero run preceding value (AC only, else 0)
out_value  out  COEF_W  signed coefficient (DC/AC), 0 for ZRL/EOB
out_last  out  1  final symbol of current block
busy  out  1  high in SCAN state

Behaviour:
- Clock/reset: one clock CLK_I; RST_I is synchronous and active-high.
- Reset values: state=FILL, wr_cnt=0, zz_idx=0, run=0, out_valid=0, out_type/out_run/out_value/out_last=0, busy=0. in_ready reads 0 while RST_I is high and 1 on the first cycle after.
- Reset mid-operation: any partial or scanning block is discarded, with no further symbols.
- Storage: 64 x COEF_W register array.
- FILL state:
  - in_ready=1.
  - Each in_valid&&in_ready writes buf[wr_cnt] and increments wr_cnt.
  - The write at wr_cnt=63 moves to SCAN on the same edge, with zz_idx=0, run=0, wr_cnt wrapping to 0.
- SCAN state:
  - in_ready=0, busy=1.
  - The scanner advances only when the output slot is free: !out_valid || out_ready.
  - When out_valid && !out_ready, the scanner and all out_* fields hold stable.
- Per advancing cycle, with c = buf[zigzag(zz_idx)]:
  - zz_idx=0: emit DC(value=c, run=0). Zero DC is still emitted. zz_idx++.
  - zz_idx 1..63, c==0, zz_idx<63: no symbol; run++, zz_idx++. Costs one cycle per coefficient.
  - zz_idx==63, c==0: emit EOB with out_last=1. Pending run of any length is dropped, so no ZRL precedes EOB.
  - c!=0, run>=16: emit ZRL; run-=16; zz_idx holds. Repeats until run<16.
  - c!=0, run<16: emit AC(run, c); run=0; out_last=(zz_idx==63); zz_idx++.
- Block end: when the symbol with out_last=1 is handshaken, the state returns to FILL on that edge. in_ready=1 from the next cycle. Consecutive blocks need no idle cycles beyond this.
- Latency: the beat-63 input handshake at edge N enters SCAN. The DC symbol is registered at edge N+1, so out_valid is high after N+1.
- Arithmetic: run counter is 6 bits internally (0..63). out_run carries run[3:0], which is always <16 when emitted. out_value passes COEF_W bits unchanged, so -128 is legal. DC differencing is not done here; the entropy coder owns it.
- Ignored inputs: in_valid is ignored in SCAN. out_ready is ignored while out_valid=0.

Decomposition:
- Package jpeg_rle_pkg:
  - symbol type enum (SYM_DC, SYM_AC, SYM_ZRL, SYM_EOB)
  - COEF_W/RUN_W defaults
  - block size constant 64
  - 64-entry zig-zag table: zz index -> raster address (0,1,8,16,9,2,3,10,...,63)
- Sub-module jpeg_zigzag_rom: combinational 6-bit zz index -> 6-bit raster address lookup on the package table.

Test Plan:
- All-zero block, out_ready=1 -> exactly DC(0), EOB(last=1); in_ready returns 1 the cycle after EOB handshake.
- raster[0]=5, raster[1]=-3, raster[8]=2, rest 0 -> DC(5), AC(0,-3), AC(0,2), EOB(last).
- raster[0]=1, raster[48]=7 (zz 21), rest 0 -> DC(1), ZRL, AC(run=4,7), EOB(last).
- raster[0]=0, raster[63]=-128, rest 0 -> DC(0), ZRL, ZRL, ZRL, AC(run=14,-128) with last=1, no EOB.
- Block 2 test with out_ready toggled randomly, including 5-cycle stalls -> identical symbol sequence; out_* stable during every stall; no lost or duplicated symbols.
- RST_I high for 1 cycle while the scan is mid-block after 2 symbols -> out_valid=0, in_ready=1 next cycle; a fresh all-zero block yields only DC(0), EOB.
